// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with dead-time guard slots and a frame-synchronous shadow buffer.
// Optional macro LEAD_ZERO_BLANK_EN blanks leading zero digits (digit 0 is always shown).
module seven_seg_scan_ctrl #(
  parameter int CLK_DIV   = 100000,
  parameter int GUARD_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        disp_on,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [1:0]  select,
  output logic        led_enable,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick,
  output logic        pending
);

  localparam int CNT_MAX = (CLK_DIV > GUARD_CYC) ? CLK_DIV : GUARD_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_SHOW  = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [15:0]      active_r, shadow_r, active_s;
  logic [3:0]       dp_active_r, dp_shadow_r, dp_active_s;
  logic [1:0]       select_s;
  logic             pending_s;
  logic             show_end_s, guard_end_s, boundary_s;
  logic             led_s, blank_s;
  logic [3:0]       nibble_s;
  logic [6:0]       seg_s;
  logic             dp_s;

  // Hex nibble to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign show_end_s  = (state_r == ST_SHOW)  && (cnt_r == CNT_W'(CLK_DIV - 1));
  assign guard_end_s = (state_r == ST_GUARD) && (cnt_r == CNT_W'(GUARD_CYC - 1));
  assign boundary_s  = guard_end_s && (select == 2'd3);

  // Next state and next digit index
  always_comb begin
    state_s  = state_r;
    select_s = select;
    case (state_r)
      ST_OFF: begin
        if (disp_on) begin
          state_s  = ST_SHOW;
          select_s = 2'd0;
        end else begin
          state_s  = ST_OFF;
        end
      end
      ST_SHOW: begin
        if (!disp_on || show_end_s) begin
          state_s = ST_GUARD;
        end else begin
          state_s = ST_SHOW;
        end
      end
      ST_GUARD: begin
        if (guard_end_s && disp_on) begin
          state_s  = ST_SHOW;
          select_s = select + 2'd1;
        end else if (guard_end_s) begin
          state_s  = ST_OFF;
          select_s = 2'd0;
        end else begin
          state_s  = ST_GUARD;
        end
      end
      default: begin
        state_s  = ST_OFF;
        select_s = 2'd0;
      end
    endcase
  end

  // Active buffer / pending flag; a direct load supersedes any stale shadow
  always_comb begin
    active_s    = active_r;
    dp_active_s = dp_active_r;
    pending_s   = pending;
    if (load && ((state_r == ST_OFF) || boundary_s)) begin
      active_s    = value;
      dp_active_s = dp_in;
      pending_s   = 1'b0;
    end else if (boundary_s && pending) begin
      active_s    = shadow_r;
      dp_active_s = dp_shadow_r;
      pending_s   = 1'b0;
    end else if (load) begin
      pending_s   = 1'b1;
    end else begin
      pending_s   = pending;
    end
  end

  // Output decode, computed from next-cycle state so registered outputs line up with it
  always_comb begin
    led_s    = (state_s == ST_SHOW);
    nibble_s = active_s[{select_s, 2'b00} +: 4];
`ifdef LEAD_ZERO_BLANK_EN
    case (select_s)
      2'd1:    blank_s = (active_s[15:4]  == 12'h000);
      2'd2:    blank_s = (active_s[15:8]  == 8'h00);
      2'd3:    blank_s = (active_s[15:12] == 4'h0);
      default: blank_s = 1'b0;
    endcase
`else
    blank_s  = 1'b0;
`endif
    if (led_s && !blank_s) begin
      seg_s = hex_to_seg(nibble_s);
    end else begin
      seg_s = 7'h7F;
    end
    if (led_s) begin
      dp_s = ~dp_active_s[select_s];
    end else begin
      dp_s = 1'b1;
    end
  end

  // State and slot counter; counter restarts on every state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_OFF;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      if ((state_s != state_r) || (state_r == ST_OFF)) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Display buffers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_r    <= 16'h0000;
      dp_active_r <= 4'h0;
      shadow_r    <= 16'h0000;
      dp_shadow_r <= 4'h0;
    end else begin
      active_r    <= active_s;
      dp_active_r <= dp_active_s;
      if (load && (state_r != ST_OFF) && !boundary_s) begin
        shadow_r    <= value;
        dp_shadow_r <= dp_in;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      select     <= 2'd0;
      led_enable <= 1'b0;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
      pending    <= 1'b0;
    end else begin
      select     <= select_s;
      led_enable <= led_s;
      seg        <= seg_s;
      dp         <= dp_s;
      frame_tick <= boundary_s;
      pending    <= pending_s;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl at CLK_DIV=4, GUARD_CYC=2 (24-cycle frame).
// Define LEAD_ZERO_BLANK_EN for both bench and RTL to check the blanking build.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset, disp_on, load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [1:0]  select;
  logic        led_enable, dp, frame_tick, pending;
  logic [6:0]  seg;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  seven_seg_scan_ctrl #(.CLK_DIV(4), .GUARD_CYC(2)) dut (
    .clk(clk), .reset(reset), .disp_on(disp_on), .load(load),
    .value(value), .dp_in(dp_in), .select(select), .led_enable(led_enable),
    .seg(seg), .dp(dp), .frame_tick(frame_tick), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; disp_on = 1'b0; load = 1'b0; value = 16'h0000; dp_in = 4'h0;
    #23;
    checks++;
    if ({select, led_enable, seg, dp, frame_tick, pending} !== {2'd0, 1'b0, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got sel=%0d en=%b seg=%h dp=%b tick=%b pend=%b", select, led_enable, seg, dp, frame_tick, pending);
    end
    reset = 1'b0;
    step(); step(); step();
    checks++;
    if (led_enable !== 1'b0 || seg !== 7'h7F) begin
      failures++;
      $display("FAIL off_idle got en=%b seg=%h expected en=0 seg=7f", led_enable, seg);
    end
  endtask

  task automatic test_scan();
    logic [6:0] tab [4];
    logic [6:0] exp_seg;
    tab[0] = 7'b0011001; tab[1] = 7'b0110000; tab[2] = 7'b0100100; tab[3] = 7'b1111001;
    pulse_load(16'h1234, 4'h0);
    checks++;
    if (pending !== 1'b0) begin
      failures++;
      $display("FAIL off_load_pending got %b expected 0", pending);
    end
    disp_on = 1'b1;
    cyc = -1;
    for (int k = 0; k < 24; k++) begin
      step();
      exp_seg = ((k % 6) < 4) ? tab[k / 6] : 7'h7F;
      checks++;
      if (select !== 2'(k / 6) || led_enable !== ((k % 6) < 4) || seg !== exp_seg || dp !== 1'b1 || frame_tick !== 1'b0) begin
        failures++;
        $display("FAIL scan k=%0d got sel=%0d en=%b seg=%b dp=%b tick=%b expected sel=%0d en=%b seg=%b",
                 k, select, led_enable, seg, dp, frame_tick, k / 6, ((k % 6) < 4), exp_seg);
      end
    end
  endtask

  task automatic test_frame_timing();
    for (int k = 24; k < 72; k++) begin
      step();
      checks++;
      if (frame_tick !== ((k % 24) == 0)) begin
        failures++;
        $display("FAIL frame_tick k=%0d got %b expected %b", cyc, frame_tick, ((k % 24) == 0));
      end
    end
  endtask

  task automatic test_shadow_update();
    logic [6:0] tab [4];
    tab[0] = 7'b0011001; tab[1] = 7'b0110000; tab[2] = 7'b0100100; tab[3] = 7'b1111001;
    wait_until(78);
    checks++;
    if (select !== 2'd1 || led_enable !== 1'b1) begin
      failures++;
      $display("FAIL pre_load_slot got sel=%0d en=%b expected sel=1 en=1", select, led_enable);
    end
    pulse_load(16'hABCD, 4'h0);
    while (cyc < 96) begin
      checks++;
      if (pending !== 1'b1 || ((cyc % 6) == 0 && seg !== tab[(cyc % 24) / 6])) begin
        failures++;
        $display("FAIL shadow_hold k=%0d got pend=%b seg=%b expected pend=1 seg=%b", cyc, pending, seg, tab[(cyc % 24) / 6]);
      end
      step();
    end
    checks++;
    if (pending !== 1'b0 || frame_tick !== 1'b1 || select !== 2'd0 || seg !== 7'b0100001) begin
      failures++;
      $display("FAIL shadow_swap got pend=%b tick=%b sel=%0d seg=%b expected pend=0 tick=1 sel=0 seg=0100001", pending, frame_tick, select, seg);
    end
    wait_until(102);
    checks++;
    if (seg !== 7'b1000110) begin
      failures++;
      $display("FAIL shadow_digit1 got seg=%b expected 1000110", seg);
    end
  endtask

  task automatic test_disable();
    wait_until(108);
    checks++;
    if (select !== 2'd2 || led_enable !== 1'b1) begin
      failures++;
      $display("FAIL pre_disable got sel=%0d en=%b expected sel=2 en=1", select, led_enable);
    end
    disp_on = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (led_enable !== 1'b0 || seg !== 7'h7F || select !== 2'd2) begin
        failures++;
        $display("FAIL disable_guard i=%0d got en=%b seg=%h sel=%0d expected en=0 seg=7f sel=2", i, led_enable, seg, select);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (led_enable !== 1'b0 || seg !== 7'h7F || select !== 2'd0 || frame_tick !== 1'b0) begin
        failures++;
        $display("FAIL disable_off i=%0d got en=%b seg=%h sel=%0d tick=%b expected en=0 seg=7f sel=0", i, led_enable, seg, select, frame_tick);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    disp_on = 1'b1;
    cyc = -1;
    step();
    pulse_load(16'h5555, 4'h0);
    wait_until(19);
    checks++;
    if (select !== 2'd3 || led_enable !== 1'b1 || seg !== 7'b0001000 || pending !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset got sel=%0d en=%b seg=%b pend=%b expected sel=3 en=1 seg=0001000 pend=1", select, led_enable, seg, pending);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({select, led_enable, seg, dp, frame_tick, pending} !== {2'd0, 1'b0, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got sel=%0d en=%b seg=%h dp=%b tick=%b pend=%b", select, led_enable, seg, dp, frame_tick, pending);
    end
    #2;
    reset = 1'b0;
    cyc = -1;
    step();
    checks++;
    if (select !== 2'd0 || led_enable !== 1'b1 || seg !== 7'b1000000) begin
      failures++;
      $display("FAIL restart got sel=%0d en=%b seg=%b expected sel=0 en=1 seg=1000000", select, led_enable, seg);
    end
  endtask

  task automatic test_lead_zero();
    logic [6:0] exp_a [4];
    logic [6:0] exp_b [4];
    logic [3:0] exp_dp;
`ifdef LEAD_ZERO_BLANK_EN
    exp_a[0] = 7'b1000000; exp_a[1] = 7'b0010010; exp_a[2] = 7'h7F;       exp_a[3] = 7'h7F;
    exp_b[0] = 7'b1000000; exp_b[1] = 7'h7F;       exp_b[2] = 7'h7F;       exp_b[3] = 7'h7F;
`else
    exp_a[0] = 7'b1000000; exp_a[1] = 7'b0010010; exp_a[2] = 7'b1000000; exp_a[3] = 7'b1000000;
    exp_b[0] = 7'b1000000; exp_b[1] = 7'b1000000; exp_b[2] = 7'b1000000; exp_b[3] = 7'b1000000;
`endif
    exp_dp = 4'b1010;
    disp_on = 1'b0;
    for (int i = 0; i < 8; i++) step();
    pulse_load(16'h0050, 4'b0101);
    disp_on = 1'b1;
    cyc = -1;
    step();
    for (int d = 0; d < 4; d++) begin
      wait_until(d * 6);
      checks++;
      if (seg !== exp_a[d] || dp !== exp_dp[d]) begin
        failures++;
        $display("FAIL lead_0050 digit=%0d got seg=%b dp=%b expected seg=%b dp=%b", d, seg, dp, exp_a[d], exp_dp[d]);
      end
    end
    pulse_load(16'h0000, 4'h0);
    for (int d = 0; d < 4; d++) begin
      wait_until(24 + d * 6);
      checks++;
      if (seg !== exp_b[d] || dp !== 1'b1) begin
        failures++;
        $display("FAIL lead_0000 digit=%0d got seg=%b dp=%b expected seg=%b dp=1", d, seg, dp, exp_b[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    wait_until(50);
    pulse_load(16'h1111, 4'h0);
    wait_until(52);
    pulse_load(16'h2222, 4'h0);
    checks++;
    if (pending !== 1'b1) begin
      failures++;
      $display("FAIL b2b_pending got %b expected 1", pending);
    end
    wait_until(72);
    checks++;
    if (seg !== 7'b0100100 || pending !== 1'b0 || frame_tick !== 1'b1) begin
      failures++;
      $display("FAIL last_load_wins got seg=%b pend=%b tick=%b expected seg=0100100 pend=0 tick=1", seg, pending, frame_tick);
    end
    wait_until(74);
    pulse_load(16'h0009, 4'h0);
    wait_until(95);
    pulse_load(16'h8887, 4'h0);
    checks++;
    if (seg !== 7'b1111000 || pending !== 1'b0 || frame_tick !== 1'b1 || select !== 2'd0) begin
      failures++;
      $display("FAIL boundary_bypass got seg=%b pend=%b tick=%b sel=%0d expected seg=1111000 pend=0 tick=1 sel=0", seg, pending, frame_tick, select);
    end
    wait_until(102);
    checks++;
    if (seg !== 7'b0000000 || select !== 2'd1) begin
      failures++;
      $display("FAIL bypass_digit1 got seg=%b sel=%0d expected seg=0000000 sel=1", seg, select);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_frame_timing();
    test_shadow_update();
    test_disable();
    test_reset_mid_frame();
    test_lead_zero();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
